rob_commit: RTL and testbench

- Reorder buffer for the Tomasulo core: the issue/commit side of the rename protocol the register file consumes.
- Allocates one entry per issued instruction and drives the register file's rename inputs (new_reg_id/new_ROB_id).
- Captures CDB results, answers operand-forwarding queries by ROB id, and retires in order: register write-back, store release, or branch flush.

---
 rtl/rob_commit_pkg.sv | 8 +
 rtl/rob_commit_query_port.sv | 20 ++
 rtl/rob_commit.sv | 148 ++++++++++++++
 tb/tb_rob_commit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: entry type codes shared by the reorder buffer and its users
package rob_commit_pkg;
    typedef enum logic [1:0] {
        ROB_TYPE_REG = 2'd0,
        ROB_TYPE_BR  = 2'd1,
        ROB_TYPE_ST  = 2'd2
    } rob_type_e;
endpackage

// File: rtl/rob_commit_query_port.sv
// rob_query_port: one operand-forwarding lookup, with the live CDB taking priority over stored values
module rob_query_port #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic [ROB_WIDTH_BIT-1:0]      id,
    input  logic [2**ROB_WIDTH_BIT-1:0]   ready_vec,
    input  logic [31:0]                   val_arr [2**ROB_WIDTH_BIT],
    input  logic                          cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0]      cdb_rob_id,
    input  logic [31:0]                   cdb_val,
    output logic                          ready,
    output logic [31:0]                   val
);
    logic hit;
    always_comb begin
        hit   = cdb_valid && cdb_rob_id == id;
        ready = hit || ready_vec[id];
        val   = hit ? cdb_val : val_arr[id];
    end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that allocates, captures CDB results, forwards operands and retires in order
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_pred_taken,
    input  logic [31:0]              issue_alt_pc,
    output logic                     full,
    output logic [ROB_WIDTH_BIT-1:0] tail_id,
    output logic [4:0]               new_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_val,
    input  logic                     cdb_taken,
    input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
    output logic                     rs1_ready,
    output logic [31:0]              rs1_val,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
    output logic                     rs2_ready,
    output logic [31:0]              rs2_val,
    output logic [4:0]               write_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    output logic [31:0]              write_val,
    output logic                     store_commit,
    output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
    output logic                     clear_flag,
    output logic [31:0]              redirect_pc
);
    localparam int DEPTH = 2**ROB_WIDTH_BIT;
    logic [ROB_WIDTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH_BIT:0]   count_q, count_d;
    logic [DEPTH-1:0]         valid_q, valid_d, ready_q, ready_d, pred_q, pred_d, taken_q, taken_d;
    rob_type_e                type_q [DEPTH];
    rob_type_e                type_d [DEPTH];
    logic [4:0]               rd_q [DEPTH];
    logic [4:0]               rd_d [DEPTH];
    logic [31:0]              val_q [DEPTH];
    logic [31:0]              val_d [DEPTH];
    logic [31:0]              alt_q [DEPTH];
    logic [31:0]              alt_d [DEPTH];
    logic                     clear_q, clear_d;
    logic [31:0]              redirect_q, redirect_d;
    logic                     issue_ok, commit_ok, mispredict, cdb_ok, commit_reg;
    always_comb begin
        full       = count_q[ROB_WIDTH_BIT];
        issue_ok   = rdy_in && !clear_q && !full && issue_valid;
        commit_ok  = rdy_in && !clear_q && valid_q[head_q] && ready_q[head_q];
        commit_reg = commit_ok && type_q[head_q] == ROB_TYPE_REG;
        mispredict = commit_ok && type_q[head_q] == ROB_TYPE_BR && taken_q[head_q] != pred_q[head_q];
        cdb_ok     = rdy_in && !clear_q && cdb_valid && valid_q[cdb_rob_id];
        tail_id      = tail_q;
        new_ROB_id   = tail_q;
        new_reg_id   = (issue_ok && issue_type == ROB_TYPE_REG) ? issue_rd : 5'd0;
        write_reg_id = commit_reg ? rd_q[head_q] : 5'd0;
        write_ROB_id = commit_reg ? head_q : '0;
        write_val    = commit_reg ? val_q[head_q] : 32'd0;
        store_commit = commit_ok && type_q[head_q] == ROB_TYPE_ST;
        store_rob_id = store_commit ? head_q : '0;
        clear_flag   = clear_q;
        redirect_pc  = redirect_q;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        ready_d = ready_q;
        pred_d  = pred_q;
        taken_d = taken_q;
        type_d  = type_q;
        rd_d    = rd_q;
        val_d   = val_q;
        alt_d   = alt_q;
        if (cdb_ok) begin
            ready_d[cdb_rob_id] = 1'b1;
            val_d[cdb_rob_id]   = cdb_val;
            taken_d[cdb_rob_id] = cdb_taken;
        end
        if (commit_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ROB_WIDTH_BIT'(1);
        end
        if (issue_ok) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = issue_type == ROB_TYPE_ST;
            type_d[tail_q]  = rob_type_e'(issue_type);
            rd_d[tail_q]    = issue_rd;
            pred_d[tail_q]  = issue_pred_taken;
            alt_d[tail_q]   = issue_alt_pc;
            tail_d          = tail_q + ROB_WIDTH_BIT'(1);
        end
        count_d = count_q + (ROB_WIDTH_BIT+1)'(issue_ok) - (ROB_WIDTH_BIT+1)'(commit_ok);
        // a wrong-path branch discards everything younger, including an issue in the same cycle
        if (mispredict) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        clear_d    = rdy_in ? mispredict : clear_q;
        redirect_d = rdy_in ? (mispredict ? alt_q[head_q] : 32'd0) : redirect_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            ready_q    <= '0;
            pred_q     <= '0;
            taken_q    <= '0;
            type_q     <= '{default: ROB_TYPE_REG};
            rd_q       <= '{default: '0};
            val_q      <= '{default: '0};
            alt_q      <= '{default: '0};
            clear_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            pred_q     <= pred_d;
            taken_q    <= taken_d;
            type_q     <= type_d;
            rd_q       <= rd_d;
            val_q      <= val_d;
            alt_q      <= alt_d;
            clear_q    <= clear_d;
            redirect_q <= redirect_d;
        end
    end
    rob_query_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_q1 (
        .id(rs1_id), .ready_vec(ready_q), .val_arr(val_q), .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .ready(rs1_ready), .val(rs1_val)
    );
    rob_query_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_q2 (
        .id(rs2_id), .ready_vec(ready_q), .val_arr(val_q), .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .ready(rs2_ready), .val(rs2_val)
    );
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed stimulus checked against an in-order queue model of the reorder buffer
module tb_rob_commit;
    localparam int D = 8;
    logic        clk_in = 0, rst_in = 1, rdy_in = 1;
    logic        issue_valid = 0, issue_pred_taken = 0;
    logic [1:0]  issue_type = 0;
    logic [4:0]  issue_rd = 0;
    logic [31:0] issue_alt_pc = 0;
    logic        cdb_valid = 0, cdb_taken = 0;
    logic [2:0]  cdb_rob_id = 0, rs1_id = 0, rs2_id = 0;
    logic [31:0] cdb_val = 0;
    logic        full, rs1_ready, rs2_ready, store_commit, clear_flag;
    logic [2:0]  tail_id, new_ROB_id, write_ROB_id, store_rob_id;
    logic [4:0]  new_reg_id, write_reg_id;
    logic [31:0] rs1_val, rs2_val, write_val, redirect_pc;
    int n_cmp = 0, n_bad = 0;

    always #5 clk_in = ~clk_in;

    rob_commit #(.ROB_WIDTH_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .full(full), .tail_id(tail_id), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .rs1_id(rs1_id), .rs1_ready(rs1_ready), .rs1_val(rs1_val),
        .rs2_id(rs2_id), .rs2_ready(rs2_ready), .rs2_val(rs2_val),
        .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
        .store_commit(store_commit), .store_rob_id(store_rob_id),
        .clear_flag(clear_flag), .redirect_pc(redirect_pc)
    );

    typedef struct {
        int          id;
        int          typ;
        int          rd;
        logic [31:0] val;
        bit          rdy;
        bit          pred;
        bit          taken;
        logic [31:0] alt;
    } ent_t;
    ent_t        m_q[$];
    int          m_tail = 0;
    bit          m_clear = 0;
    logic [31:0] m_redir = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(int id);
        foreach (m_q[i]) if (m_q[i].id == id) return i;
        return -1;
    endfunction

    task automatic chk_rs(string nm, int id, logic rdy, logic [31:0] v);
        int k;
        if (cdb_valid && int'(cdb_rob_id) == id) begin
            chk({nm, "_ready"}, 32'(rdy), 1);
            chk({nm, "_val"}, v, cdb_val);
        end else begin
            k = find(id);
            if (k >= 0) begin
                chk({nm, "_ready"}, 32'(rdy), 32'(m_q[k].rdy));
                if (m_q[k].rdy) chk({nm, "_val"}, v, m_q[k].val);
            end
        end
    endtask

    always @(negedge clk_in) if (!rst_in) begin
        bit acc, com;
        ent_t h;
        acc = rdy_in && !m_clear && m_q.size() < D && issue_valid;
        com = rdy_in && !m_clear && m_q.size() > 0 && m_q[0].rdy;
        if (m_q.size() > 0) h = m_q[0];
        else h = '{default: 0};
        chk("full", 32'(full), 32'(m_q.size() == D));
        chk("tail_id", 32'(tail_id), m_tail);
        chk("new_ROB_id", 32'(new_ROB_id), m_tail);
        chk("new_reg_id", 32'(new_reg_id), (acc && issue_type == 0) ? 32'(issue_rd) : 0);
        chk("write_reg_id", 32'(write_reg_id), (com && h.typ == 0) ? h.rd : 0);
        chk("write_ROB_id", 32'(write_ROB_id), (com && h.typ == 0) ? h.id : 0);
        chk("write_val", write_val, (com && h.typ == 0) ? h.val : 0);
        chk("store_commit", 32'(store_commit), 32'(com && h.typ == 2));
        chk("store_rob_id", 32'(store_rob_id), (com && h.typ == 2) ? h.id : 0);
        chk("clear_flag", 32'(clear_flag), 32'(m_clear));
        chk("redirect_pc", redirect_pc, m_redir);
        chk_rs("rs1", int'(rs1_id), rs1_ready, rs1_val);
        chk_rs("rs2", int'(rs2_id), rs2_ready, rs2_val);
    end

    always @(posedge clk_in) begin
        bit acc, com, flush;
        ent_t h, n;
        int k;
        if (rst_in) begin
            m_q.delete();
            m_tail  = 0;
            m_clear = 0;
            m_redir = 0;
        end else if (rdy_in) begin
            acc   = !m_clear && m_q.size() < D && issue_valid;
            com   = !m_clear && m_q.size() > 0 && m_q[0].rdy;
            flush = 0;
            h     = '{default: 0};
            if (com) begin
                h     = m_q.pop_front();
                flush = h.typ == 1 && h.taken != h.pred;
            end
            if (cdb_valid && !m_clear) begin
                k = find(int'(cdb_rob_id));
                if (k >= 0) begin
                    m_q[k].rdy   = 1;
                    m_q[k].val   = cdb_val;
                    m_q[k].taken = cdb_taken;
                end
            end
            if (acc) begin
                n = '{m_tail, int'(issue_type), int'(issue_rd), 0, issue_type == 2, issue_pred_taken, 0, issue_alt_pc};
                m_q.push_back(n);
                m_tail = (m_tail + 1) % D;
            end
            if (flush) begin
                m_q.delete();
                m_tail = 0;
            end
            m_clear = flush;
            m_redir = flush ? h.alt : 0;
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask
    task automatic idle();
        issue_valid = 0;
        cdb_valid   = 0;
    endtask
    task automatic iss(int t, int rd, bit p, logic [31:0] a);
        issue_valid = 1;
        issue_type = 2'(t);
        issue_rd = 5'(rd);
        issue_pred_taken = p;
        issue_alt_pc = a;
    endtask
    task automatic cdb(int id, logic [31:0] v, bit tk);
        cdb_valid = 1;
        cdb_rob_id = 3'(id);
        cdb_val = v;
        cdb_taken = tk;
    endtask
    task automatic do_reset();
        rst_in = 1;
        idle();
        cyc();
        cyc();
        rst_in = 0;
    endtask

    initial begin
        cyc();
        do_reset();
        @(negedge clk_in);
        chk("rst_full", 32'(full), 0);
        chk("rst_tail", 32'(tail_id), 0);
        chk("rst_write_reg", 32'(write_reg_id), 0);
        chk("rst_store", 32'(store_commit), 0);
        chk("rst_clear", 32'(clear_flag), 0);
        chk("rst_redirect", redirect_pc, 0);
        cyc();
        // first issue and its write-back
        iss(0, 5, 0, 0);
        @(negedge clk_in);
        chk("t1_new_reg", 32'(new_reg_id), 5);
        chk("t1_new_rob", 32'(new_ROB_id), 0);
        cyc();
        idle();
        cdb(0, 32'h1234, 0);
        @(negedge clk_in);
        chk("t1_no_early_commit", 32'(write_reg_id), 0);
        cyc();
        idle();
        @(negedge clk_in);
        chk("t1_write_reg", 32'(write_reg_id), 5);
        chk("t1_write_val", write_val, 32'h1234);
        chk("t1_write_rob", 32'(write_ROB_id), 0);
        cyc();
        // fill, full-ignore, wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iss(0, i + 1, 0, 0);
            cyc();
        end
        iss(0, 20, 0, 0);
        @(negedge clk_in);
        chk("t2_full", 32'(full), 1);
        chk("t2_ignored", 32'(new_reg_id), 0);
        cyc();
        idle();
        cdb(0, 32'hA0, 0);
        cyc();
        idle();
        iss(0, 9, 0, 0);
        @(negedge clk_in);
        chk("t2_commit_reg", 32'(write_reg_id), 1);
        chk("t2_commit_val", write_val, 32'hA0);
        chk("t2_full_commit", 32'(full), 1);
        chk("t2_full_issue_ignored", 32'(new_reg_id), 0);
        cyc();
        @(negedge clk_in);
        chk("t2_not_full", 32'(full), 0);
        chk("t2_wrap_id", 32'(new_ROB_id), 0);
        chk("t2_wrap_reg", 32'(new_reg_id), 9);
        cyc();
        idle();
        @(negedge clk_in);
        chk("t2_full_again", 32'(full), 1);
        // forwarding queries
        cdb(2, 7, 0);
        rs1_id = 2;
        rs2_id = 3;
        @(negedge clk_in);
        chk("t3_rs1_ready", 32'(rs1_ready), 1);
        chk("t3_rs1_val", rs1_val, 7);
        chk("t3_rs2_ready", 32'(rs2_ready), 0);
        cyc();
        idle();
        @(negedge clk_in);
        chk("t3_rs1_stored", rs1_val, 7);
        chk("t3_no_commit", 32'(write_reg_id), 0);
        cyc();
        // out-of-order results, in-order retire, pause
        cdb(3, 32'h33, 0);
        cyc();
        cdb(1, 32'h11, 0);
        @(negedge clk_in);
        chk("t4_wait_head", 32'(write_reg_id), 0);
        cyc();
        idle();
        @(negedge clk_in);
        chk("t4_c1_reg", 32'(write_reg_id), 2);
        chk("t4_c1_val", write_val, 32'h11);
        chk("t4_c1_rob", 32'(write_ROB_id), 1);
        cyc();
        @(negedge clk_in);
        chk("t4_c2_rob", 32'(write_ROB_id), 2);
        chk("t4_c2_val", write_val, 7);
        cyc();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("t4_pause_reg", 32'(write_reg_id), 0);
            cyc();
        end
        rdy_in = 1;
        @(negedge clk_in);
        chk("t4_resume_reg", 32'(write_reg_id), 4);
        chk("t4_resume_val", write_val, 32'h33);
        chk("t4_resume_rob", 32'(write_ROB_id), 3);
        cyc();
        // store release and branch mispredict
        do_reset();
        iss(2, 0, 0, 0);
        cyc();
        iss(1, 0, 0, 32'h100);
        @(negedge clk_in);
        chk("t5_store", 32'(store_commit), 1);
        chk("t5_store_id", 32'(store_rob_id), 0);
        cyc();
        iss(0, 10, 0, 0);
        cyc();
        iss(0, 11, 0, 0);
        cdb(2, 5, 0);
        cyc();
        idle();
        cdb(1, 0, 1);
        cyc();
        idle();
        @(negedge clk_in);
        chk("t5_br_no_write", 32'(write_reg_id), 0);
        chk("t5_no_clear_yet", 32'(clear_flag), 0);
        cyc();
        iss(0, 12, 0, 0);
        cdb(3, 9, 0);
        @(negedge clk_in);
        chk("t5_clear", 32'(clear_flag), 1);
        chk("t5_redirect", redirect_pc, 32'h100);
        chk("t5_issue_blocked", 32'(new_reg_id), 0);
        chk("t5_young_flushed", 32'(write_reg_id), 0);
        cyc();
        cdb_valid = 0;
        @(negedge clk_in);
        chk("t5_clear_done", 32'(clear_flag), 0);
        chk("t5_restart_id", 32'(new_ROB_id), 0);
        chk("t5_restart_reg", 32'(new_reg_id), 12);
        cyc();
        idle();
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
